lsu_dbus_master: RTL and testbench
==================================

Name: lsu_dbus_master

Overview:
- MEM-stage load/store unit. It consumes the decoded `mem_read`/`mem_write` codes, the ALU address and the rs2 store data.
- It drives the data-memory bus through a req/gnt/rvalid handshake and stalls the pipeline until the access completes.
- It performs byte-lane steering and write-strobe generation for stores, and lane extraction with sign/zero extension for loads.
- It is the consumer end of the memory-access encoding that the decode stage produces.

Parameters:
- ADDR_W, 32, address width of core and data bus.
- DATA_W, 32, data width. Fixed at 32; the byte-enable logic assumes 4 lanes.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- mem_read  in  3  load code: 000 none, 001 LB, 010 LH, 011 LW, 100 LBU, 101 LHU; 110/111 treated as LW.
- mem_write  in  2  store code: 00 none, 01 SB, 10 SH, 11 SW.
- addr  in  32  effective address from ALU.
- wdata  in  32  store data (rs2, unaligned LSB-justified).
- lsu_stall  out  1  freeze IF/ID/EX/MEM while an access is in flight.
- load_data  out  32  aligned, extended load result to WB.
- load_valid  out  1  one-cycle pulse when load_data is updated.
- misalign  out  1  one-cycle pulse when an access is misaligned (no bus access is made).
- dbus_req  out  1  bus request.
- dbus_we  out  1  1 = write.
- dbus_addr  out  32  word-aligned address (`addr[1:0]` forced to 0).
- dbus_be  out  4  byte enables.
- dbus_wdata  out  32  lane-replicated write data.
- dbus_gnt  in  1  request accepted this cycle.
- dbus_rvalid  in  1  read data valid.
- dbus_rdata  in  32  read data.

Behaviour:
- Reset (async, rst_n=0): state IDLE. lsu_stall, load_valid, misalign, dbus_req, dbus_we, dbus_be = 0. load_data, dbus_addr, dbus_wdata = 0. Reset mid-access abandons the access; dbus_req falls immediately.
- op_valid = (mem_read != 0) | (mem_write != 0). If both are nonzero, the load wins.
- Misaligned when:
  - halfword access with `addr[0]` = 1, or
  - word access with `addr[1:0]` != 0.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - op_valid & aligned: latch dbus_addr, dbus_we, dbus_be, dbus_wdata, load type, and `addr[1:0]`. Set dbus_req=1 and go to REQ. lsu_stall=1 combinationally in this cycle.
  - op_valid & misaligned: misalign=1 (registered pulse, next cycle); lsu_stall=0; stay IDLE.
- REQ: dbus_req and all dbus_* outputs are held stable until dbus_gnt. On gnt, dbus_req is cleared; a store goes to DONE, a load goes to WAIT. lsu_stall=1.
- WAIT: on dbus_rvalid, capture the extracted result into load_data, pulse load_valid=1 in the DONE cycle, and go to DONE. lsu_stall=1. dbus_rvalid in any state other than WAIT is ignored.
- DONE: lsu_stall=0 for exactly one cycle so the pipeline advances; then go to IDLE. The instruction is not reissued.
- Minimum latency:
  - store: 3 cycles (IDLE, REQ with gnt, DONE).
  - load with rvalid the cycle after gnt: 4 cycles.
- Store steering:
  - SB: be = 0001 << `addr[1:0]`; wdata = {4{`wdata[7:0]`}}.
  - SH: be = `addr[1]` ? 1100 : 0011; wdata = {2{`wdata[15:0]`}}.
  - SW: be = 1111; wdata unchanged.
- Load extraction:
  - byte = rdata >> (8*`addr[1:0]`) [7:0]; half = rdata >> (16*`addr[1]`) [15:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes unchanged.
  - Loads drive be = 1111.
- load_data holds its value until the next completed load.
- dbus_we = 0 for loads.

Decomposition:
- Defines.vh (shared) holds the MEM_READ_* and MEM_WRITE_* codes and the LSU state encoding (2-bit localparams).
- Natural sub-module: lsu_load_align, combinational. Inputs are rdata, offset and type; output is the extended data. It is reused by a future D-cache.

Test Plan:
- SW addr=0x1004, wdata=0xDEADBEEF, gnt on the first REQ cycle -> dbus_addr=0x1004, be=1111, we=1, wdata=0xDEADBEEF; lsu_stall high for 2 cycles, low in DONE.
- SB addr=0x2003, wdata=0x000000A5 -> be=1000, dbus_wdata=0xA5A5A5A5, dbus_addr=0x2000.
- LB addr=0x3002, rdata=0x12F05634, rvalid 3 cycles after gnt -> load_data=0xFFFFFFF0, load_valid pulses once; same access as LBU -> 0x000000F0.
- LH addr=0x4001 -> misalign pulses, dbus_req stays 0, lsu_stall stays 0.
- gnt withheld for 5 cycles -> dbus_req, addr, be, wdata stable throughout; stall remains high; stray rvalid during REQ is ignored.
- rst_n low while in WAIT -> dbus_req=0, lsu_stall=0 immediately; state returns to IDLE; a later rvalid produces no load_valid.

Source files
------------

// File: rtl/lsu_dbus_master_pkg.sv
// Shared memory-access codes, LSU state type and access-size helpers for the
// MEM-stage load/store unit.
package lsu_dbus_master_pkg;

  localparam logic [2:0] MEM_READ_NONE = 3'b000;
  localparam logic [2:0] MEM_READ_LB   = 3'b001;
  localparam logic [2:0] MEM_READ_LH   = 3'b010;
  localparam logic [2:0] MEM_READ_LW   = 3'b011;
  localparam logic [2:0] MEM_READ_LBU  = 3'b100;
  localparam logic [2:0] MEM_READ_LHU  = 3'b101;

  localparam logic [1:0] MEM_WRITE_NONE = 2'b00;
  localparam logic [1:0] MEM_WRITE_SB   = 2'b01;
  localparam logic [1:0] MEM_WRITE_SH   = 2'b10;
  localparam logic [1:0] MEM_WRITE_SW   = 2'b11;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'b00,
    LSU_REQ  = 2'b01,
    LSU_WAIT = 2'b10,
    LSU_DONE = 2'b11
  } lsu_state_e;

  typedef enum logic [2:0] {LD_B, LD_BU, LD_H, LD_HU, LD_W} ld_type_e;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} acc_size_e;

  // Reserved load codes 110/111 behave as LW.
  function automatic ld_type_e decode_load(input logic [2:0] mem_read);
    case (mem_read)
      MEM_READ_LB:  return LD_B;
      MEM_READ_LBU: return LD_BU;
      MEM_READ_LH:  return LD_H;
      MEM_READ_LHU: return LD_HU;
      default:      return LD_W;
    endcase
  endfunction

  // Loads take priority over stores when both codes are nonzero.
  function automatic acc_size_e access_size(input logic [2:0] mem_read,
                                            input logic [1:0] mem_write);
    if (mem_read != MEM_READ_NONE) begin
      case (mem_read)
        MEM_READ_LB, MEM_READ_LBU: return SZ_B;
        MEM_READ_LH, MEM_READ_LHU: return SZ_H;
        default:                   return SZ_W;
      endcase
    end
    case (mem_write)
      MEM_WRITE_SB: return SZ_B;
      MEM_WRITE_SH: return SZ_H;
      default:      return SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/lsu_dbus_master_load_align.sv
// Combinational load lane extraction with sign/zero extension; shared with
// the future D-cache read path.
module lsu_load_align
  import lsu_dbus_master_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  ld_type_e    ld_type,
  output logic [31:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = 8'(rdata >> {offset, 3'b000});
  assign half_v = 16'(rdata >> {offset[1], 4'b0000});

  always_comb begin
    data = rdata;
    unique case (ld_type)
      LD_B:    data = {{24{byte_v[7]}}, byte_v};
      LD_BU:   data = {24'h000000, byte_v};
      LD_H:    data = {{16{half_v[15]}}, half_v};
      LD_HU:   data = {16'h0000, half_v};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_dbus_master.sv
// MEM-stage load/store unit: drives the req/gnt/rvalid data bus, steers store
// lanes, aligns load data and stalls the pipeline while an access is in flight.
module lsu_dbus_master
  import lsu_dbus_master_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        mem_read,
  input  logic [1:0]        mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              lsu_stall,
  output logic [DATA_W-1:0] load_data,
  output logic              load_valid,
  output logic              misalign,
  output logic              dbus_req,
  output logic              dbus_we,
  output logic [ADDR_W-1:0] dbus_addr,
  output logic [3:0]        dbus_be,
  output logic [DATA_W-1:0] dbus_wdata,
  input  logic              dbus_gnt,
  input  logic              dbus_rvalid,
  input  logic [DATA_W-1:0] dbus_rdata
);

  lsu_state_e        state_q, state_d;
  acc_size_e         size;
  logic              is_load, op_valid, misaligned, start, rd_done;
  logic [3:0]        be_n;
  logic [DATA_W-1:0] wdata_n;
  logic [1:0]        offset_q;
  ld_type_e          ld_type_q;
  logic [DATA_W-1:0] aligned;

  assign is_load    = (mem_read != MEM_READ_NONE);
  assign op_valid   = is_load | (mem_write != MEM_WRITE_NONE);
  assign size       = access_size(mem_read, mem_write);
  assign misaligned = ((size == SZ_H) && addr[0]) ||
                      ((size == SZ_W) && (addr[1:0] != 2'b00));
  assign start      = (state_q == LSU_IDLE) && op_valid && !misaligned;
  assign rd_done    = (state_q == LSU_WAIT) && dbus_rvalid;
  assign dbus_req   = (state_q == LSU_REQ);

  always_comb begin
    be_n    = '1;
    wdata_n = '0;
    if (!is_load) begin
      unique case (size)
        SZ_B: begin
          be_n    = 4'b0001 << addr[1:0];
          wdata_n = {4{wdata[7:0]}};
        end
        SZ_H: begin
          be_n    = addr[1] ? 4'b1100 : 4'b0011;
          wdata_n = {2{wdata[15:0]}};
        end
        default: begin
          be_n    = '1;
          wdata_n = wdata;
        end
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    lsu_stall = 1'b0;
    unique case (state_q)
      LSU_IDLE: begin
        if (start) begin
          state_d   = LSU_REQ;
          lsu_stall = 1'b1;
        end
      end
      LSU_REQ: begin
        lsu_stall = 1'b1;
        if (dbus_gnt) state_d = dbus_we ? LSU_DONE : LSU_WAIT;
      end
      LSU_WAIT: begin
        lsu_stall = 1'b1;
        if (dbus_rvalid) state_d = LSU_DONE;
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  lsu_load_align u_load_align (
    .rdata   (dbus_rdata),
    .offset  (offset_q),
    .ld_type (ld_type_q),
    .data    (aligned)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LSU_IDLE;
      misalign   <= 1'b0;
      load_valid <= 1'b0;
      load_data  <= '0;
      dbus_we    <= 1'b0;
      dbus_be    <= '0;
      dbus_addr  <= '0;
      dbus_wdata <= '0;
      offset_q   <= '0;
      ld_type_q  <= LD_W;
    end else begin
      state_q    <= state_d;
      misalign   <= (state_q == LSU_IDLE) && op_valid && misaligned;
      load_valid <= rd_done;
      if (start) begin
        dbus_addr  <= {addr[ADDR_W-1:2], 2'b00};
        dbus_we    <= !is_load;
        dbus_be    <= be_n;
        dbus_wdata <= wdata_n;
        offset_q   <= addr[1:0];
        ld_type_q  <= decode_load(mem_read);
      end
      if (rd_done) load_data <= aligned;
    end
  end

endmodule

// File: tb/tb_lsu_dbus_master.sv
// Randomized self-checking bench for lsu_dbus_master against a byte-lane
// reference model of the load/store rules.
module tb_lsu_dbus_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  mem_read;
  logic [1:0]  mem_write;
  logic [31:0] addr, wdata;
  logic        lsu_stall, load_valid, misalign;
  logic [31:0] load_data;
  logic        dbus_req, dbus_we;
  logic [31:0] dbus_addr, dbus_wdata;
  logic [3:0]  dbus_be;
  logic        dbus_gnt, dbus_rvalid;
  logic [31:0] dbus_rdata;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [31:0] model_ld;

  always #5 clk = ~clk;

  lsu_dbus_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .lsu_stall(lsu_stall), .load_data(load_data),
    .load_valid(load_valid), .misalign(misalign), .dbus_req(dbus_req),
    .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_be(dbus_be),
    .dbus_wdata(dbus_wdata), .dbus_gnt(dbus_gnt), .dbus_rvalid(dbus_rvalid),
    .dbus_rdata(dbus_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int unsigned ref_size(input logic [2:0] mr, input logic [1:0] mw);
    if (mr != 0) return (mr == 1 || mr == 4) ? 1 : (mr == 2 || mr == 5) ? 2 : 4;
    return (mw == 1) ? 1 : (mw == 2) ? 2 : 4;
  endfunction

  function automatic logic [3:0] ref_be(input int unsigned sz, input int unsigned off, input bit ld);
    logic [3:0] be;
    for (int i = 0; i < 4; i++) be[i] = ld || (i >= off && i < off + sz);
    return be;
  endfunction

  function automatic logic [31:0] ref_wdata(input int unsigned sz, input logic [31:0] w);
    logic [31:0] d;
    for (int i = 0; i < 4; i++)
      d[8*i +: 8] = (sz == 1) ? w[7:0] : (sz == 2) ? w[8*(i%2) +: 8] : w[8*i +: 8];
    return d;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] mr, input logic [31:0] rd,
                                           input int unsigned off);
    logic [7:0]  b [4];
    logic [15:0] h;
    for (int i = 0; i < 4; i++) b[i] = rd[8*i +: 8];
    h = {b[(off & 2) + 1], b[off & 2]};
    case (mr)
      3'd1:    return {{24{b[off][7]}}, b[off]};
      3'd4:    return {24'h0, b[off]};
      3'd2:    return {{16{h[15]}}, h};
      3'd5:    return {16'h0, h};
      default: return rd;
    endcase
  endfunction

  task automatic idle_cycle();
    @(negedge clk);
    mem_read = 3'd0; mem_write = 2'd0; dbus_gnt = 1'b0; dbus_rvalid = 1'b0;
    #1;
    check("idle_stall", lsu_stall, 0);
    check("idle_req", dbus_req, 0);
    @(posedge clk);
  endtask

  task automatic access(input logic [2:0] mr, input logic [1:0] mw, input logic [31:0] a,
                        input logic [31:0] wd, input int unsigned gnt_dly,
                        input int unsigned rv_dly, input logic [31:0] rd);
    int unsigned sz;
    bit          ld;
    logic [31:0] exp_addr, exp_wd, exp_ld;
    logic [3:0]  exp_be;
    ld       = (mr != 0);
    sz       = ref_size(mr, mw);
    exp_addr = a & 32'hFFFF_FFFC;
    exp_be   = ref_be(sz, a % 4, ld);
    exp_wd   = ref_wdata(sz, wd);
    exp_ld   = ref_load(mr, rd, a % 4);

    @(negedge clk);
    mem_read = mr; mem_write = mw; addr = a; wdata = wd;
    dbus_gnt = 1'b0; dbus_rvalid = 1'b0;
    #1;
    check("idle_misalign_low", misalign, 0);
    check("idle_load_valid_low", load_valid, 0);
    check("load_data_hold", load_data, model_ld);
    check("idle_req_low", dbus_req, 0);

    if (a % sz != 0) begin
      check("mis_stall", lsu_stall, 0);
      @(posedge clk);
      @(negedge clk);
      mem_read = 3'd0; mem_write = 2'd0;
      #1;
      check("mis_pulse", misalign, 1);
      check("mis_req", dbus_req, 0);
      check("mis_stall_next", lsu_stall, 0);
      @(posedge clk);
      return;
    end

    check("idle_stall", lsu_stall, 1);
    @(posedge clk);

    for (int k = 0; k <= int'(gnt_dly); k++) begin
      @(negedge clk);
      dbus_gnt    = (k == int'(gnt_dly));
      dbus_rvalid = 1'($urandom_range(0, 1));
      dbus_rdata  = $urandom;
      #1;
      check("req_req", dbus_req, 1);
      check("req_stall", lsu_stall, 1);
      check("req_addr", dbus_addr, exp_addr);
      check("req_be", dbus_be, exp_be);
      check("req_we", dbus_we, !ld);
      if (!ld) check("req_wdata", dbus_wdata, exp_wd);
      check("req_load_valid", load_valid, 0);
      @(posedge clk);
    end

    if (ld) begin
      for (int k = 0; k <= int'(rv_dly); k++) begin
        @(negedge clk);
        dbus_gnt    = 1'b0;
        dbus_rvalid = (k == int'(rv_dly));
        dbus_rdata  = (k == int'(rv_dly)) ? rd : $urandom;
        #1;
        check("wait_req", dbus_req, 0);
        check("wait_stall", lsu_stall, 1);
        check("wait_load_valid", load_valid, 0);
        @(posedge clk);
      end
    end

    @(negedge clk);
    dbus_gnt    = 1'b0;
    dbus_rvalid = 1'($urandom_range(0, 1));
    dbus_rdata  = $urandom;
    #1;
    check("done_stall", lsu_stall, 0);
    check("done_req", dbus_req, 0);
    check("done_load_valid", load_valid, ld);
    if (ld) model_ld = exp_ld;
    check("done_load_data", load_data, model_ld);
    @(posedge clk);
  endtask

  initial begin
    logic [2:0]  mr;
    logic [1:0]  mw;
    logic [31:0] a;
    rst_n = 1'b0; mem_read = 3'd0; mem_write = 2'd0; addr = '0; wdata = '0;
    dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = '0;
    model_ld = '0;
    #1;
    check("rst_stall", lsu_stall, 0);
    check("rst_load_valid", load_valid, 0);
    check("rst_misalign", misalign, 0);
    check("rst_req", dbus_req, 0);
    check("rst_we", dbus_we, 0);
    check("rst_be", dbus_be, 0);
    check("rst_load_data", load_data, 0);
    check("rst_addr", dbus_addr, 0);
    check("rst_wdata", dbus_wdata, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle_cycle();

    access(3'd0, 2'd3, 32'h0000_1004, 32'hDEAD_BEEF, 0, 0, 32'h0);
    access(3'd0, 2'd1, 32'h0000_2003, 32'h0000_00A5, 0, 0, 32'h0);
    access(3'd1, 2'd0, 32'h0000_3002, 32'h0, 0, 2, 32'h12F0_5634);
    access(3'd4, 2'd0, 32'h0000_3002, 32'h0, 1, 2, 32'h12F0_5634);
    access(3'd2, 2'd0, 32'h0000_4001, 32'h0, 0, 0, 32'h0);
    access(3'd0, 2'd3, 32'h0000_5008, 32'h1234_5678, 5, 0, 32'h0);
    access(3'd5, 2'd0, 32'h0000_600E, 32'h0, 5, 0, 32'h8001_7FFE);
    access(3'd2, 2'd2, 32'h0000_7002, 32'hCAFE_F00D, 0, 0, 32'h9ABC_DEF0);
    access(3'd7, 2'd0, 32'h0000_8004, 32'h0, 0, 1, 32'h0BAD_F00D);
    access(3'd0, 2'd2, 32'h0000_9002, 32'h0000_BEEF, 0, 0, 32'h0);
    access(3'd0, 2'd3, 32'h0000_A002, 32'h1111_2222, 0, 0, 32'h0);
    idle_cycle();

    // Reset asserted while a load is waiting for rvalid
    @(negedge clk);
    mem_read = 3'd3; mem_write = 2'd0; addr = 32'h0000_B000;
    @(negedge clk);
    dbus_gnt = 1'b1;
    @(negedge clk);
    dbus_gnt = 1'b0; mem_read = 3'd0;
    #1;
    check("rstwait_stall_before", lsu_stall, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rstwait_req", dbus_req, 0);
    check("rstwait_stall", lsu_stall, 0);
    check("rstwait_load_data", load_data, 0);
    model_ld = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    dbus_rvalid = 1'b1; dbus_rdata = 32'h5555_AAAA;
    @(negedge clk);
    dbus_rvalid = 1'b0;
    #1;
    check("rstwait_no_load_valid", load_valid, 0);
    check("rstwait_load_data_hold", load_data, 0);
    check("rstwait_idle_stall", lsu_stall, 0);
    @(posedge clk);

    for (int n = 0; n < 150; n++) begin
      a = $urandom;
      case ($urandom_range(0, 2))
        0: begin mr = 3'($urandom_range(1, 7)); mw = 2'd0; end
        1: begin mr = 3'd0; mw = 2'($urandom_range(1, 3)); end
        default: begin mr = 3'($urandom_range(1, 7)); mw = 2'($urandom_range(1, 3)); end
      endcase
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      access(mr, mw, a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
      if ($urandom_range(0, 7) == 0) idle_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
